// File: rtl/axi_frame_writer.sv
// Write-side frame master: drains a FWFT pixel FIFO into fixed-length AXI INCR
// write bursts, rotating frames through BUF_NUM DDR buffers.
module axi_frame_writer #(
  parameter int          BURST_LEN   = 16,
  parameter logic [31:0] FRAME_BASE  = 32'h0000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0020_0000,
  parameter int          FRAME_WORDS = 76800,
  parameter int          BUF_NUM     = 3,
  parameter int          CNT_W       = 10,
  parameter logic [7:0]  AXI_ID      = 8'h00
) (
  input  logic               Axi_Clk,
  input  logic               Axi_Rst,
  input  logic               frame_start,
  input  logic [CNT_W-1:0]   fifo_rd_cnt,
  input  logic [127:0]       fifo_rd_data,
  output logic               fifo_rd_en,
  output logic [31:0]        DdrCtrl_AADDR_0,
  output logic [1:0]         DdrCtrl_ABURST_0,
  output logic [7:0]         DdrCtrl_AID_0,
  output logic [7:0]         DdrCtrl_ALEN_0,
  output logic [1:0]         DdrCtrl_ALOCK_0,
  output logic [2:0]         DdrCtrl_ASIZE_0,
  output logic               DdrCtrl_ATYPE_0,
  output logic               DdrCtrl_AVALID_0,
  input  logic               DdrCtrl_AREADY_0,
  output logic [127:0]       DdrCtrl_WDATA_0,
  output logic [7:0]         DdrCtrl_WID_0,
  output logic               DdrCtrl_WLAST_0,
  output logic [15:0]        DdrCtrl_WSTRB_0,
  output logic               DdrCtrl_WVALID_0,
  input  logic               DdrCtrl_WREADY_0,
  input  logic [7:0]         DdrCtrl_BID_0,
  input  logic               DdrCtrl_BVALID_0,
  output logic               DdrCtrl_BREADY_0,
  output logic               frame_done,
  output logic [1:0]         rd_frame_idx
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 16);
  localparam logic [31:0] BURST_WORDS = 32'(BURST_LEN);
  localparam logic [31:0] FRAME_WLIM  = 32'(FRAME_WORDS);
  localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [1:0]  LAST_BUF    = 2'(BUF_NUM - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} stateT;

  stateT       stateReg, stateNext;
  logic        pendReg, pendNext;
  logic        firstReg, firstNext;
  logic        activeReg, activeNext;
  logic [1:0]  wrIdxReg, wrIdxNext;
  logic [1:0]  rdIdxReg, rdIdxNext;
  logic [31:0] addrReg, addrNext;
  logic [31:0] wordsReg, wordsNext;
  logic [8:0]  beatReg, beatNext;
  logic        frameDoneReg, frameDoneNext;
  logic [1:0]  newIdx;
  logic [31:0] wordsInc;
  logic        burstReady;
  logic        unusedBid;

  // Response ID carries nothing useful: only one ID is ever outstanding.
  assign unusedBid  = ^DdrCtrl_BID_0;
  assign wordsInc   = wordsReg + BURST_WORDS;
  assign burstReady = 32'(fifo_rd_cnt) >= BURST_WORDS;

  always_comb begin
    stateNext     = stateReg;
    pendNext      = pendReg | frame_start;
    firstNext     = firstReg;
    activeNext    = activeReg;
    wrIdxNext     = wrIdxReg;
    rdIdxNext     = rdIdxReg;
    addrNext      = addrReg;
    wordsNext     = wordsReg;
    beatNext      = beatReg;
    frameDoneNext = 1'b0;
    newIdx        = 2'd0;
    case (stateReg)
      IDLE: begin
        if (pendReg) begin
          // A new frame start is only honoured between bursts.
          pendNext   = frame_start;
          newIdx     = (firstReg || wrIdxReg == LAST_BUF) ? 2'd0 : wrIdxReg + 2'd1;
          wrIdxNext  = newIdx;
          firstNext  = 1'b0;
          addrNext   = FRAME_BASE + 32'(newIdx) * FRAME_BYTES;
          wordsNext  = 32'd0;
          activeNext = 1'b1;
        end else if (activeReg && burstReady) begin
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (DdrCtrl_AREADY_0) begin
          stateNext = DATA;
          beatNext  = 9'd0;
        end
      end
      DATA: begin
        if (DdrCtrl_WREADY_0) begin
          beatNext = beatReg + 9'd1;
          if (beatReg == LAST_BEAT) stateNext = RESP;
        end
      end
      RESP: begin
        if (DdrCtrl_BVALID_0) begin
          addrNext  = addrReg + BURST_BYTES;
          wordsNext = wordsInc;
          stateNext = IDLE;
          // An aborted frame never publishes its buffer.
          if (wordsInc == FRAME_WLIM && !pendReg) begin
            frameDoneNext = 1'b1;
            rdIdxNext     = wrIdxReg;
            activeNext    = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Axi_Clk) begin
    if (Axi_Rst) begin
      stateReg     <= IDLE;
      pendReg      <= 1'b0;
      firstReg     <= 1'b1;
      activeReg    <= 1'b0;
      wrIdxReg     <= 2'd0;
      rdIdxReg     <= 2'd0;
      addrReg      <= 32'd0;
      wordsReg     <= 32'd0;
      beatReg      <= 9'd0;
      frameDoneReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      pendReg      <= pendNext;
      firstReg     <= firstNext;
      activeReg    <= activeNext;
      wrIdxReg     <= wrIdxNext;
      rdIdxReg     <= rdIdxNext;
      addrReg      <= addrNext;
      wordsReg     <= wordsNext;
      beatReg      <= beatNext;
      frameDoneReg <= frameDoneNext;
    end
  end

  assign DdrCtrl_ABURST_0 = 2'b01;
  assign DdrCtrl_ALOCK_0  = 2'b00;
  assign DdrCtrl_ASIZE_0  = 3'b100;
  assign DdrCtrl_ATYPE_0  = 1'b1;
  assign DdrCtrl_ALEN_0   = 8'(BURST_LEN - 1);
  assign DdrCtrl_AID_0    = AXI_ID;
  assign DdrCtrl_WID_0    = AXI_ID;
  assign DdrCtrl_WSTRB_0  = 16'hFFFF;

  assign DdrCtrl_AVALID_0 = (stateReg == ADDR);
  assign DdrCtrl_AADDR_0  = addrReg;
  assign DdrCtrl_WVALID_0 = (stateReg == DATA);
  // FWFT head goes straight onto the bus; it only advances on a pop.
  assign DdrCtrl_WDATA_0  = DdrCtrl_WVALID_0 ? fifo_rd_data : 128'd0;
  assign DdrCtrl_WLAST_0  = DdrCtrl_WVALID_0 && (beatReg == LAST_BEAT);
  assign fifo_rd_en       = DdrCtrl_WVALID_0 && DdrCtrl_WREADY_0;
  assign DdrCtrl_BREADY_0 = (stateReg == RESP);
  assign frame_done       = frameDoneReg;
  assign rd_frame_idx     = rdIdxReg;

endmodule
